// File: rtl/aux_state_controller_rf.sv
// AUX pin state controller: tracks UART/RF activity and mode changes, asserting AUX once the link has settled.
// Optional build macro AUX_STATUS_EN adds the aux_status[1:0] state-code output.
module aux_state_controller_rf #(
  parameter logic [1:0] DEFAULT_MODE       = 2'd3,
  parameter int         SETTLE_CYCLES      = 2000,
  parameter int         MODE_SETTLE_CYCLES = 1000
) (
  input  logic       internal_clk,
  input  logic       rst,
  input  logic       M0_sync,
  input  logic       M1_sync,
  input  logic       AUX_mode_ctrl,
  input  logic       uart_rx_busy,
  input  logic       rf_tx_busy,
  input  logic       rf_rx_busy,
  output logic       AUX_state_ctrl,
  output logic       AUX
`ifdef AUX_STATUS_EN
  ,
  output logic [1:0] aux_status
`endif
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > MODE_SETTLE_CYCLES) ? SETTLE_CYCLES
                                                                   : MODE_SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] MODE_LIM   = CNT_W'(MODE_SETTLE_CYCLES);

  // Encoding doubles as the externally visible status code.
  typedef enum logic [1:0] {
    ST_READY  = 2'b00,
    ST_BUSY   = 2'b01,
    ST_SETTLE = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic [1:0]       mode_prev;
  logic [1:0]       mode_cur;
  logic             any_busy;
  logic             mode_chg;
  logic             settle_done;

  assign mode_cur    = {M1_sync, M0_sync};
  assign any_busy    = uart_rx_busy | rf_tx_busy | rf_rx_busy;
  assign mode_chg    = (mode_cur != mode_prev);
  assign settle_done = (cnt == (limit - 1'b1));

  // Busy always wins over a coincident mode change; the counter stops at limit-1 so it never wraps.
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state          <= ST_READY;
      cnt            <= '0;
      limit          <= SETTLE_LIM;
      mode_prev      <= DEFAULT_MODE;
      AUX_state_ctrl <= 1'b1;
      AUX            <= 1'b0;
    end else begin
      mode_prev <= mode_cur;
      AUX       <= AUX_state_ctrl & AUX_mode_ctrl;
      unique case (state)
        ST_READY: begin
          if (any_busy) begin
            state          <= ST_BUSY;
            cnt            <= '0;
            AUX_state_ctrl <= 1'b0;
          end else if (mode_chg) begin
            state          <= ST_SETTLE;
            limit          <= MODE_LIM;
            cnt            <= '0;
            AUX_state_ctrl <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!any_busy) begin
            state <= ST_SETTLE;
            limit <= SETTLE_LIM;
            cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (any_busy) begin
            state <= ST_BUSY;
            cnt   <= '0;
          end else if (mode_chg) begin
            limit <= MODE_LIM;
            cnt   <= '0;
          end else if (settle_done) begin
            state          <= ST_READY;
            cnt            <= '0;
            AUX_state_ctrl <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state          <= ST_READY;
          cnt            <= '0;
          AUX_state_ctrl <= 1'b1;
        end
      endcase
    end
  end

`ifdef AUX_STATUS_EN
  assign aux_status = state;
`endif

endmodule

// File: tb/tb_aux_state_controller_rf.sv
// Directed bench for aux_state_controller_rf with SETTLE_CYCLES=8, MODE_SETTLE_CYCLES=4.
module tb_aux_state_controller_rf;

  logic internal_clk = 1'b0;
  logic rst, M0_sync, M1_sync, AUX_mode_ctrl;
  logic uart_rx_busy, rf_tx_busy, rf_rx_busy;
  logic AUX_state_ctrl, AUX;
`ifdef AUX_STATUS_EN
  logic [1:0] aux_status;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 internal_clk = ~internal_clk;

  aux_state_controller_rf #(
    .DEFAULT_MODE      (2'd3),
    .SETTLE_CYCLES     (8),
    .MODE_SETTLE_CYCLES(4)
  ) dut (
    .internal_clk  (internal_clk),
    .rst           (rst),
    .M0_sync       (M0_sync),
    .M1_sync       (M1_sync),
    .AUX_mode_ctrl (AUX_mode_ctrl),
    .uart_rx_busy  (uart_rx_busy),
    .rf_tx_busy    (rf_tx_busy),
    .rf_rx_busy    (rf_rx_busy),
    .AUX_state_ctrl(AUX_state_ctrl),
    .AUX           (AUX)
`ifdef AUX_STATUS_EN
    ,
    .aux_status    (aux_status)
`endif
  );

  task automatic tick();
    @(posedge internal_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; M1_sync = 1'b1; M0_sync = 1'b1; AUX_mode_ctrl = 1'b1;
    uart_rx_busy = 1'b0; rf_tx_busy = 1'b0; rf_rx_busy = 1'b0;

    // Reset state, AUX follows one cycle after release
    tick();
    check("rst_asc", AUX_state_ctrl, 1);
    check("rst_aux", AUX, 0);
`ifdef AUX_STATUS_EN
    check("rst_status", aux_status, 0);
`endif
    rst = 1'b0;
    tick();
    check("rel_aux", AUX, 1);
    check("rel_asc", AUX_state_ctrl, 1);

    // rf_tx_busy high for 5 cycles, release after 9 edges
    rf_tx_busy = 1'b1;
    tick();
    check("tx_rise_asc", AUX_state_ctrl, 0);
`ifdef AUX_STATUS_EN
    check("tx_status_busy", aux_status, 1);
`endif
    repeat (4) tick();
    rf_tx_busy = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) check("tx_fall1_asc", AUX_state_ctrl, 0);
      if (k == 8) check("tx_fall8_asc", AUX_state_ctrl, 0);
      if (k == 9) check("tx_fall9_asc", AUX_state_ctrl, 1);
      if (k == 9) check("tx_fall9_aux", AUX, 0);
      if (k == 10) check("tx_fall10_aux", AUX, 1);
    end

    // Single-cycle pulse, then uart pulse at settle counter 5 restarts full settle
    rf_tx_busy = 1'b1;
    tick();
    check("pulse_asc", AUX_state_ctrl, 0);
    rf_tx_busy = 1'b0;
    repeat (6) tick();
`ifdef AUX_STATUS_EN
    check("settle_status", aux_status, 2);
`endif
    uart_rx_busy = 1'b1;
    tick();
    uart_rx_busy = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k == 3) check("restart_k3_asc", AUX_state_ctrl, 0);
      if (k == 9) check("restart_k9_asc", AUX_state_ctrl, 0);
      if (k == 10) check("restart_k10_asc", AUX_state_ctrl, 1);
    end

    // Mode 3->0 while idle: low for exactly 4 cycles
    M1_sync = 1'b0; M0_sync = 1'b0;
    tick();
    check("mode_e0_asc", AUX_state_ctrl, 0);
    repeat (3) tick();
    check("mode_e3_asc", AUX_state_ctrl, 0);
    tick();
    check("mode_e4_asc", AUX_state_ctrl, 1);

    // Mode 0->2, then 2->1 at settle cycle 2 restarts the 4-cycle settle
    M1_sync = 1'b1; M0_sync = 1'b0;
    tick();
    tick();
    tick();
    M1_sync = 1'b0; M0_sync = 1'b1;
    for (int k = 3; k <= 7; k++) begin
      tick();
      if (k == 4) check("mrestart_e4_asc", AUX_state_ctrl, 0);
      if (k == 6) check("mrestart_e6_asc", AUX_state_ctrl, 0);
      if (k == 7) check("mrestart_e7_asc", AUX_state_ctrl, 1);
    end

    // Coincident mode change and rf_rx_busy: busy wins, long settle applies
    M1_sync = 1'b0; M0_sync = 1'b0; rf_rx_busy = 1'b1;
    tick();
    check("coinc_asc", AUX_state_ctrl, 0);
`ifdef AUX_STATUS_EN
    check("coinc_status", aux_status, 1);
`endif
    tick();
    tick();
    rf_rx_busy = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) check("coinc_k5_asc", AUX_state_ctrl, 0);
      if (k == 8) check("coinc_k8_asc", AUX_state_ctrl, 0);
      if (k == 9) check("coinc_k9_asc", AUX_state_ctrl, 1);
      if (k == 9) check("coinc_k9_aux", AUX, 0);
      if (k == 10) check("coinc_k10_aux", AUX, 1);
    end

    // Reset mid-SETTLE with AUX_mode_ctrl=0
    AUX_mode_ctrl = 1'b0;
    M1_sync = 1'b1; M0_sync = 1'b1;
    tick();
    tick();
    check("pre_rst_asc", AUX_state_ctrl, 0);
    rst = 1'b1; rf_tx_busy = 1'b1;
    tick();
    check("midrst_asc", AUX_state_ctrl, 1);
    check("midrst_aux", AUX, 0);
`ifdef AUX_STATUS_EN
    check("midrst_status", aux_status, 0);
`endif
    rf_tx_busy = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_aux_gated", AUX, 0);
    check("post_rst_asc", AUX_state_ctrl, 1);
    AUX_mode_ctrl = 1'b1;
    tick();
    check("post_rst_aux", AUX, 1);

    // mode_prev resets to DEFAULT_MODE: mode 0 after reset triggers a mode settle
    rst = 1'b1;
    M1_sync = 1'b0; M0_sync = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("defmode_asc", AUX_state_ctrl, 0);
    repeat (3) tick();
    check("defmode_e3_asc", AUX_state_ctrl, 0);
    tick();
    check("defmode_e4_asc", AUX_state_ctrl, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
